// File: rtl/rmii_pkg.sv
// rtl/rmii_pkg.sv - shared states and constants for the RMII transmit path
package rmii_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        DATA,
        PAD,
        FCS,
        IFG
    } state_t;

    typedef enum logic [1:0] {
        CRC_OP_HOLD,
        CRC_OP_INIT,
        CRC_OP_UPD,
        CRC_OP_SHIFT
    } crc_op_t;

    localparam logic [7:0]  SFD      = 8'hD5;
    localparam logic [7:0]  PRE_BYTE = 8'h55;
    localparam logic [31:0] CRC_POLY = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;

endpackage

// File: rtl/crc32_d2.sv
// rtl/crc32_d2.sv - reflected CRC-32 next-state for one dibit, bit 0 first
module crc32_d2
    import rmii_pkg::*;
(
    input  logic [31:0] crc_i,
    input  logic [1:0]  dibit_i,
    output logic [31:0] crc_o
);

    logic [31:0] s1;

    assign s1    = {1'b0, crc_i[31:1]} ^ ((crc_i[0] ^ dibit_i[0]) ? CRC_POLY : 32'h0);
    assign crc_o = {1'b0, s1[31:1]}    ^ ((s1[0]    ^ dibit_i[1]) ? CRC_POLY : 32'h0);

endmodule

// File: rtl/rmii_tx_framer.sv
// rtl/rmii_tx_framer.sv - RMII transmit framer: preamble/SFD, zero pad, CRC-32 FCS, IFG
module rmii_tx_framer
    import rmii_pkg::*;
#(
    parameter int PREAMBLE_BYTES = 7,
    parameter int MIN_FRAME      = 60,
    parameter int PAD_EN         = 1,
    parameter int IFG_BYTES      = 12
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    input  logic       in_last,
    output logic       in_ready,
    output logic       rmii_tx_en,
    output logic       rmii_tx0,
    output logic       rmii_tx1,
    output logic       busy,
    output logic       underrun
);

    localparam int CNT_W   = 16;
    localparam int BC_W    = (MIN_FRAME > 0) ? $clog2(MIN_FRAME + 1) : 1;
    localparam int IFG_CYC = IFG_BYTES * 4;

    localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'((PREAMBLE_BYTES + 1) * 4 - 1);
    localparam logic [CNT_W-1:0] FCS_LAST = CNT_W'(15);
    // IFG state is one cycle short: the IDLE cycle that samples in_valid completes the gap
    localparam logic [CNT_W-1:0] IFG_LAST = CNT_W'((IFG_CYC >= 2) ? IFG_CYC - 2 : 0);
    localparam logic [BC_W-1:0]  MIN_BC   = BC_W'(MIN_FRAME);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       dib_q, dib_d;
    logic [7:0]       sh_q, sh_d;
    logic             last_q, last_d;
    logic [BC_W-1:0]  byte_cnt_q, byte_cnt_d;
    logic [31:0]      crc_q, crc_d;
    logic             tx_en_q, tx_en_d;
    logic [1:0]       tx_q, tx_d;
    logic             in_ready_q, in_ready_d;
    logic             underrun_q, underrun_d;
    logic             busy_q, busy_d;

    crc_op_t          crc_op;
    logic [1:0]       crc_din;
    logic [31:0]      crc_nxt;
    logic             load, pad_start, fcs_start, abort;
    logic [BC_W-1:0]  bc_inc;

    assign bc_inc = (byte_cnt_q < MIN_BC) ? byte_cnt_q + BC_W'(1) : byte_cnt_q;

    crc32_d2 u_crc (
        .crc_i   (crc_q),
        .dibit_i (crc_din),
        .crc_o   (crc_nxt)
    );

    // State registers always describe the dibit currently on the pins
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dib_d      = dib_q;
        sh_d       = sh_q;
        last_d     = last_q;
        byte_cnt_d = byte_cnt_q;
        tx_en_d    = tx_en_q;
        tx_d       = tx_q;
        in_ready_d = 1'b0;
        underrun_d = 1'b0;
        crc_op     = CRC_OP_HOLD;
        crc_din    = 2'b00;
        load       = 1'b0;
        pad_start  = 1'b0;
        fcs_start  = 1'b0;
        abort      = 1'b0;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d    = PRE;
                    cnt_d      = '0;
                    tx_en_d    = 1'b1;
                    tx_d       = PRE_BYTE[1:0];
                    byte_cnt_d = '0;
                    crc_op     = CRC_OP_INIT;
                end
            end
            PRE: begin
                if (cnt_q != PRE_LAST) begin
                    cnt_d      = cnt_q + CNT_W'(1);
                    tx_d       = (cnt_d == PRE_LAST) ? SFD[7:6] : PRE_BYTE[1:0];
                    in_ready_d = (cnt_d == PRE_LAST);
                end else if (in_valid) begin
                    load = 1'b1;
                end else begin
                    abort = 1'b1;
                end
            end
            DATA: begin
                if (dib_q != 2'd3) begin
                    tx_d       = sh_q[1:0];
                    sh_d       = {2'b00, sh_q[7:2]};
                    crc_op     = CRC_OP_UPD;
                    crc_din    = sh_q[1:0];
                    dib_d      = dib_q + 2'd1;
                    in_ready_d = (dib_q == 2'd2) && !last_q;
                end else if (!last_q) begin
                    if (in_valid) begin
                        load = 1'b1;
                    end else begin
                        abort = 1'b1;
                    end
                end else if ((PAD_EN != 0) && (byte_cnt_q < MIN_BC)) begin
                    pad_start = 1'b1;
                end else begin
                    fcs_start = 1'b1;
                end
            end
            PAD: begin
                if (dib_q != 2'd3) begin
                    tx_d   = 2'b00;
                    crc_op = CRC_OP_UPD;
                    dib_d  = dib_q + 2'd1;
                end else if (byte_cnt_q < MIN_BC) begin
                    pad_start = 1'b1;
                end else begin
                    fcs_start = 1'b1;
                end
            end
            FCS: begin
                if (cnt_q != FCS_LAST) begin
                    cnt_d  = cnt_q + CNT_W'(1);
                    tx_d   = ~crc_q[1:0];
                    crc_op = CRC_OP_SHIFT;
                end else begin
                    state_d = IFG;
                    cnt_d   = '0;
                    tx_en_d = 1'b0;
                    tx_d    = 2'b00;
                end
            end
            IFG: begin
                if (cnt_q == IFG_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            state_d    = DATA;
            tx_d       = in_data[1:0];
            sh_d       = {2'b00, in_data[7:2]};
            crc_op     = CRC_OP_UPD;
            crc_din    = in_data[1:0];
            dib_d      = 2'd0;
            last_d     = in_last;
            byte_cnt_d = bc_inc;
        end
        if (pad_start) begin
            state_d    = PAD;
            tx_d       = 2'b00;
            crc_op     = CRC_OP_UPD;
            dib_d      = 2'd0;
            last_d     = 1'b0;
            byte_cnt_d = bc_inc;
        end
        // The CRC register doubles as the FCS shift register once data is done
        if (fcs_start) begin
            state_d = FCS;
            cnt_d   = '0;
            tx_d    = ~crc_q[1:0];
            crc_op  = CRC_OP_SHIFT;
        end
        if (abort) begin
            state_d    = IFG;
            cnt_d      = '0;
            tx_en_d    = 1'b0;
            tx_d       = 2'b00;
            underrun_d = 1'b1;
        end

        busy_d = (state_d != IDLE);
    end

    always_comb begin
        crc_d = crc_q;
        case (crc_op)
            CRC_OP_INIT:  crc_d = CRC_INIT;
            CRC_OP_UPD:   crc_d = crc_nxt;
            CRC_OP_SHIFT: crc_d = {2'b00, crc_q[31:2]};
            default:      crc_d = crc_q;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            dib_q      <= 2'd0;
            sh_q       <= 8'h00;
            last_q     <= 1'b0;
            byte_cnt_q <= '0;
            crc_q      <= CRC_INIT;
            tx_en_q    <= 1'b0;
            tx_q       <= 2'b00;
            in_ready_q <= 1'b0;
            underrun_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dib_q      <= dib_d;
            sh_q       <= sh_d;
            last_q     <= last_d;
            byte_cnt_q <= byte_cnt_d;
            crc_q      <= crc_d;
            tx_en_q    <= tx_en_d;
            tx_q       <= tx_d;
            in_ready_q <= in_ready_d;
            underrun_q <= underrun_d;
            busy_q     <= busy_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign rmii_tx_en = tx_en_q;
    assign rmii_tx0   = tx_q[0];
    assign rmii_tx1   = tx_q[1];
    assign busy       = busy_q;
    assign underrun   = underrun_q;

endmodule

// File: tb/tb_rmii_tx_framer.sv
// tb/tb_rmii_tx_framer.sv - directed self-checking bench for rmii_tx_framer
module tb_rmii_tx_framer;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_last = 1'b0;
    logic       sel_np = 1'b1;

    logic rdy_p, en_p, tx0_p, tx1_p, busy_p, und_p;
    logic rdy_n, en_n, tx0_n, tx1_n, busy_n, und_n;
    logic valid_p, valid_n;
    logic rdy_m, en_m, tx0_m, tx1_m, busy_m, und_m;

    int tests_run = 0;
    int tests_failed = 0;

    logic [7:0] frm [0:63];
    logic [7:0] cap [0:511];
    logic [5:0] smp [$];
    bit         logging = 1'b0;
    int         rise, len, e, k, cnt, rise2, len2;

    always #10 clk = ~clk;

    assign valid_n = in_valid & sel_np;
    assign valid_p = in_valid & ~sel_np;
    assign rdy_m   = sel_np ? rdy_n  : rdy_p;
    assign en_m    = sel_np ? en_n   : en_p;
    assign tx0_m   = sel_np ? tx0_n  : tx0_p;
    assign tx1_m   = sel_np ? tx1_n  : tx1_p;
    assign busy_m  = sel_np ? busy_n : busy_p;
    assign und_m   = sel_np ? und_n  : und_p;

    rmii_tx_framer #(.PAD_EN(1)) u_dut_pad (
        .clk        (clk),
        .resetn     (resetn),
        .in_data    (in_data),
        .in_valid   (valid_p),
        .in_last    (in_last),
        .in_ready   (rdy_p),
        .rmii_tx_en (en_p),
        .rmii_tx0   (tx0_p),
        .rmii_tx1   (tx1_p),
        .busy       (busy_p),
        .underrun   (und_p)
    );

    rmii_tx_framer #(.PAD_EN(0)) u_dut_nopad (
        .clk        (clk),
        .resetn     (resetn),
        .in_data    (in_data),
        .in_valid   (valid_n),
        .in_last    (in_last),
        .in_ready   (rdy_n),
        .rmii_tx_en (en_n),
        .rmii_tx0   (tx0_n),
        .rmii_tx1   (tx1_n),
        .busy       (busy_n),
        .underrun   (und_n)
    );

    always @(negedge clk) begin
        if (logging) smp.push_back({und_m, busy_m, rdy_m, en_m, tx1_m, tx0_m});
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'h0, b};
        for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    task automatic start_log();
        smp.delete();
        logging = 1'b1;
    endtask

    task automatic send_frame(input int n, input bit hold, input int drop_idx);
        int idx = 0;
        int guard = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_last  = 1'b0;
        in_data  = 8'($urandom);
        while (idx < n && guard < 4000) begin
            if (rdy_m) begin
                if (idx == drop_idx) begin
                    in_valid = 1'b0;
                    idx = n;
                end else begin
                    in_data = frm[idx];
                    in_last = (idx == n - 1);
                    idx++;
                end
            end else begin
                in_data = 8'($urandom);
            end
            @(negedge clk);
            guard++;
        end
        check("drv_timeout", 32'(guard < 4000), 32'd1);
        in_valid = hold;
        in_last  = 1'b0;
        in_data  = 8'($urandom);
    endtask

    task automatic wait_idle();
        int g = 0;
        @(negedge clk);
        while ((busy_p || busy_n) && g < 2000) begin
            @(negedge clk);
            g++;
        end
        check("idle_timeout", 32'(g < 2000), 32'd1);
        repeat (4) @(negedge clk);
        logging = 1'b0;
    endtask

    // Locate the first tx_en burst at or after index 'from' and unpack its dibits into bytes
    task automatic find_burst(input int from, output int r, output int l);
        r = -1;
        l = 0;
        for (int i = from; i < smp.size(); i++) begin
            if (smp[i][2]) begin
                r = i;
                break;
            end
        end
        if (r >= 0) begin
            while (r + l < smp.size() && smp[r + l][2]) l++;
        end
        for (int i = 0; i < 512; i++) cap[i] = 8'h00;
        for (int i = 0; i < l && i < 2048; i++) cap[i / 4][(i % 4) * 2 +: 2] = smp[r + i][1:0];
    endtask

    task automatic check_pre(input string tag);
        int good = 0;
        for (int i = 0; i < 7; i++) if (cap[i] == 8'h55) good++;
        check({tag, "_preamble"}, good, 7);
        check({tag, "_sfd"}, cap[7], 8'hD5);
    endtask

    task automatic check_residue(input string tag, input int nbytes);
        logic [31:0] c = 32'hFFFFFFFF;
        for (int i = 8; i < 8 + nbytes; i++) c = crc_byte(c, cap[i]);
        check({tag, "_residue"}, c, 32'hDEBB20E3);
    endtask

    task automatic check_data(input string tag, input int n);
        int bad = 0;
        for (int i = 0; i < n; i++) if (cap[8 + i] !== frm[i]) bad++;
        check({tag, "_data"}, bad, 0);
    endtask

    function automatic logic [31:0] fcs_at(input int idx);
        return {cap[idx + 3], cap[idx + 2], cap[idx + 1], cap[idx]};
    endfunction

    task automatic load_digits();
        for (int i = 0; i < 9; i++) frm[i] = 8'h31 + 8'(i);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_tx_en", en_n, 1'b0);
        check("rst_in_ready", rdy_n, 1'b0);
        check("rst_busy", busy_n, 1'b0);
        check("rst_underrun_dibit", {und_n, tx1_n, tx0_n}, 3'b000);
        resetn = 1'b1;
        repeat (2) @(negedge clk);

        // "123456789" unpadded
        sel_np = 1'b1;
        load_digits();
        start_log();
        send_frame(9, 1'b0, -1);
        wait_idle();
        find_burst(0, rise, len);
        check("t1_len", len, 84);
        check_pre("t1");
        check_data("t1", 9);
        check("t1_fcs", fcs_at(17), 32'hCBF43926);
        check_residue("t1", 13);
        k = -1;
        for (int i = 0; i < smp.size(); i++) begin
            if (smp[i][3] && k < 0) k = i;
        end
        check("t1_ready_pos", k - rise, 31);

        // 42-byte ARP-style reply, padded to 60
        sel_np = 1'b0;
        for (int i = 0; i < 42; i++) frm[i] = 8'(i * 29 + 17);
        start_log();
        send_frame(42, 1'b0, -1);
        wait_idle();
        find_burst(0, rise, len);
        check("t2_len", len, 288);
        check_pre("t2");
        check_data("t2", 42);
        cnt = 0;
        for (int i = 50; i < 68; i++) if (cap[i] == 8'h00) cnt++;
        check("t2_pad_zero", cnt, 18);
        check_residue("t2", 64);

        // back-to-back with in_valid held through the gap
        sel_np = 1'b1;
        load_digits();
        start_log();
        send_frame(9, 1'b1, -1);
        send_frame(9, 1'b0, -1);
        wait_idle();
        find_burst(0, rise, len);
        check("t3_len1", len, 84);
        e = rise + len;
        cnt = 0;
        k = 0;
        for (int i = e; i < smp.size() && !smp[i][2]; i++) begin
            cnt++;
            if (smp[i][3]) k++;
        end
        check("t3_gap", cnt, 48);
        check("t3_gap_ready", k, 0);
        find_burst(e, rise2, len2);
        check("t3_len2", len2, 84);
        check("t3_fcs2", fcs_at(17), 32'hCBF43926);

        // underrun on the 5th byte's ready cycle
        for (int i = 0; i < 10; i++) frm[i] = 8'hA0 + 8'(i);
        start_log();
        send_frame(10, 1'b0, 4);
        wait_idle();
        find_burst(0, rise, len);
        check("t4_len", len, 48);
        e = rise + len;
        check("t4_underrun_at_drop", (e < smp.size()) ? smp[e][5] : 1'b0, 1'b1);
        cnt = 0;
        for (int i = 0; i < smp.size(); i++) if (smp[i][5]) cnt++;
        check("t4_underrun_count", cnt, 1);
        cnt = 0;
        for (int i = e; i < smp.size() && smp[i][4]; i++) cnt++;
        check("t4_busy_after_drop", cnt, 47);

        // asynchronous reset in the middle of DATA
        @(negedge clk);
        in_valid = 1'b1;
        in_last  = 1'b0;
        repeat (60) begin
            @(negedge clk);
            in_data = 8'($urandom);
        end
        check("t5_pre_tx_en", en_n, 1'b1);
        #1 resetn = 1'b0;
        #1;
        check("t5_rst_tx_en", en_n, 1'b0);
        check("t5_rst_ready_busy", {rdy_n, busy_n}, 2'b00);
        in_valid = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        load_digits();
        start_log();
        send_frame(9, 1'b0, -1);
        wait_idle();
        find_burst(0, rise, len);
        check("t5_len", len, 84);
        check_pre("t5");
        check("t5_fcs", fcs_at(17), 32'hCBF43926);

        // single 0xA5 byte with in_last on the SFD ready cycle
        sel_np = 1'b0;
        frm[0] = 8'hA5;
        start_log();
        send_frame(1, 1'b0, -1);
        wait_idle();
        find_burst(0, rise, len);
        check("t6_len", len, 288);
        check("t6_dibits", {smp[rise + 32][1:0], smp[rise + 33][1:0], smp[rise + 34][1:0], smp[rise + 35][1:0]}, 8'b01_01_10_10);
        cnt = 0;
        for (int i = 9; i < 68; i++) if (cap[i] == 8'h00) cnt++;
        check("t6_pad_zero", cnt, 59);
        check_residue("t6", 64);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
